fib_arbiter: RTL and testbench

Round-robin scheduler that shares one `fib` core between `N` requesters. It accepts one request at a time, drives the core's `ready`/`in_n` start handshake, waits for `valid`, and acknowledges with `accept`. It then returns the captured result to the granted requester. It sits between the requesting channels (RPC dispatchers or testbench masters) and the single `fib` instance.

---
 rtl/fib_arbiter.sv | 121 ++++++++++++
 tb/tb_fib_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin scheduler sharing one fib core
// between N requesters via start/valid/accept handshakes.
module fib_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_n,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  input  logic [N-1:0]   rsp_accept,
  output logic           fib_ready,
  output logic [W-1:0]   fib_in_n,
  input  logic           fib_valid,
  input  logic [W-1:0]   fib_out_0,
  output logic           fib_accept,
  output logic           busy,
  output logic [IW-1:0]  grant_id,
  output logic [15:0]    jobs_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]     state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  win;
  logic           found;
  logic [W-1:0]   win_n;
  logic [W-1:0]   result;
  logic [2*N-1:0] dbl;
  logic [IW:0]    sum;
  logic           take;

  // Rotate requests so bit 0 is the ptr position; first set bit wins.
  always_comb begin
    dbl   = {req_valid, req_valid} >> ptr;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(N))
          sum = sum - (IW+1)'(N);
        win   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    win_n = '0;
    for (int i = 0; i < N; i++)
      if (win == IW'(i))
        win_n = req_n[i*W +: W];
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = (state == IDLE) && found
                     && (win == IW'(i));
      rsp_valid[i] = (state == RESP)
                     && (grant_id == IW'(i));
    end
  end

  assign take       = |(rsp_accept & rsp_valid);
  assign fib_ready  = (state == START);
  assign fib_accept = (state == ACK);
  assign busy       = (state != IDLE);
  assign rsp_data   = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      fib_in_n  <= '0;
      result    <= '0;
      jobs_done <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            fib_in_n <= win_n;
            grant_id <= win;
            ptr      <= (win == IW'(N-1)) ? '0
                        : win + 1'b1;
            state    <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (fib_valid) begin
            result <= fib_out_0;
            state  <= ACK;
          end
        end
        ACK: state <= RESP;
        RESP: begin
          if (take) begin
            jobs_done <= jobs_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: scoreboard bench for fib_arbiter with a
// behavioural fib core and auto-retiring requesters.
module tb_fib_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_n;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [N-1:0]   rsp_accept;
  logic           fib_ready;
  logic [W-1:0]   fib_in_n;
  logic           fib_valid;
  logic [W-1:0]   fib_out_0;
  logic           fib_accept;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic [15:0]    jobs_done;

  logic           core_valid;
  logic           stray;
  logic [W-1:0]   core_n;
  logic [N-1:0]   rr;
  int             lat;
  int             cnt;
  int             ready_cnt;
  int             accept_cnt;
  int             done_jobs;
  int             checks;
  int             errors;
  exp_t           sb[$];

  assign fib_valid = core_valid | stray;

  fib_arbiter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_n      (req_n),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_accept (rsp_accept),
    .fib_ready  (fib_ready),
    .fib_in_n   (fib_in_n),
    .fib_valid  (fib_valid),
    .fib_out_0  (fib_out_0),
    .fib_accept (fib_accept),
    .busy       (busy),
    .grant_id   (grant_id),
    .jobs_done  (jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fib_ref(input int n);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int n);
    req_n[id*W +: W] = n;
    req_valid[id]    = 1'b1;
  endtask

  task automatic expect_rsp(input int id, input int n);
    exp_t e;
    e.id   = id;
    e.data = fib_ref(n);
    sb.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " req_ready"}, req_ready, 0);
    check({tag, " rsp_valid"}, rsp_valid, 0);
    check({tag, " rsp_data"}, rsp_data, 0);
    check({tag, " fib_ready"}, fib_ready, 0);
    check({tag, " fib_in_n"}, fib_in_n, 0);
    check({tag, " fib_accept"}, fib_accept, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " grant_id"}, grant_id, 0);
    check({tag, " jobs_done"}, jobs_done, 0);
  endtask

  // Wait for a response, compare with the scoreboard head,
  // optionally hold it (driving stray accepts), then accept.
  task automatic collect(input string tag, input int hold,
                         input logic [N-1:0] stray_acc,
                         output int waited);
    exp_t        e;
    logic [N-1:0] v0;
    logic [W-1:0] d0;
    logic [15:0]  j0;
    waited = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0 || waited >= 100) break;
      waited++;
    end
    if (rsp_valid == '0) begin
      check({tag, " timeout"}, 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, " unexpected"}, rsp_valid, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, " id"}, rsp_valid, 64'd1 << e.id);
    check({tag, " data"}, rsp_data, e.data);
    v0 = rsp_valid;
    d0 = rsp_data;
    j0 = jobs_done;
    for (int i = 0; i < hold; i++) begin
      rsp_accept = stray_acc;
      @(negedge clk);
      check({tag, " hold"},
            {rsp_valid, rsp_data, req_ready, busy,
             fib_accept, jobs_done},
            {v0, d0, 4'b0000, 1'b1, 1'b0, j0});
    end
    rsp_accept = rsp_valid;
    sync();
    rsp_accept = '0;
    done_jobs++;
  endtask

  // Requesters drop req_valid once their grant is seen.
  initial begin
    forever begin
      @(negedge clk);
      rr = req_ready;
      if (rr != '0) begin
        sync();
        req_valid = req_valid & ~rr;
      end
    end
  end

  // Behavioural fib core with programmable latency.
  initial begin
    core_valid = 1'b0;
    fib_out_0  = '0;
    core_n     = '0;
    cnt        = -1;
    ready_cnt  = 0;
    accept_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        core_valid = 1'b0;
        cnt        = -1;
      end else begin
        if (fib_accept) begin
          accept_cnt++;
          core_valid = 1'b0;
        end
        if (fib_ready) begin
          ready_cnt++;
          core_n = fib_in_n;
          cnt    = lat;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_valid = 1'b1;
            fib_out_0  = fib_ref(core_n);
            cnt        = -1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          w;
    int          a0;
    checks     = 0;
    errors     = 0;
    done_jobs  = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_n      = '0;
    rsp_accept = '0;
    stray      = 1'b0;
    lat        = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    for (int n = 0; n < 4; n++) begin
      sync();
      set_req(0, n);
      expect_rsp(0, n);
      collect($sformatf("seq%0d", n), 0, '0, w);
      if (n == 0) check("latency", w, 4);
    end
    @(negedge clk);
    check("seq jobs_done", jobs_done, 4);
    check("seq ready pulses", ready_cnt, 4);
    check("seq accept pulses", accept_cnt, 4);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sync();
    for (int i = 0; i < N; i++) begin
      set_req(i, 5 + i);
      expect_rsp(i, 5 + i);
    end
    for (int i = 0; i < N; i++)
      collect($sformatf("all%0d", i), 0, '0, w);
    @(negedge clk);
    check("all jobs_done", jobs_done, 4);

    sync();
    set_req(1, 4);
    expect_rsp(1, 4);
    collect("fair1", 0, '0, w);
    sync();
    set_req(0, 3);
    set_req(3, 7);
    expect_rsp(3, 7);
    expect_rsp(0, 3);
    collect("fair3", 0, '0, w);
    collect("fair0", 0, '0, w);

    sync();
    set_req(0, 9);
    expect_rsp(0, 9);
    sync();
    sync();
    set_req(2, 11);
    expect_rsp(2, 11);
    collect("bp0", 10, '0, w);
    @(negedge clk);
    check("bp grant", req_ready, 4'b0100);
    collect("bp2", 0, '0, w);

    lat = 8;
    sync();
    set_req(1, 10);
    repeat (3) sync();
    @(negedge clk);
    check("mid wait busy", {busy, fib_ready}, 2'b10);
    #1 rst = 1'b1;
    #1 check_reset("async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    sync();
    set_req(1, 10);
    expect_rsp(1, 10);
    collect("post reset", 0, '0, w);

    sync();
    set_req(1, 6);
    expect_rsp(1, 6);
    collect("stray acc", 3, 4'b1000, w);
    a0 = accept_cnt;
    sync();
    stray = 1'b1;
    sync();
    stray = 1'b0;
    @(negedge clk);
    check("stray fv busy", busy, 0);
    check("stray fv jobs", jobs_done, 2);
    check("stray fv accepts", accept_cnt, a0);

    sync();
    set_req(3, 12);
    expect_rsp(3, 12);
    collect("final", 0, '0, w);
    @(negedge clk);
    check("scoreboard empty", sb.size(), 0);
    check("accepts vs jobs", accept_cnt, done_jobs);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
